// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM states, error causes
// and small decode helpers.
package rv32_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } lsu_state_t;

  localparam logic [1:0] ERR_MISALIGN = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    if (store) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  // f3[1:0] carries the access size for both signed and unsigned loads.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lsu_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/rv32_lsu_if.sv
// Data-memory req/gnt/rvalid bus between the load/store unit (master) and memory (slave).
interface rv32_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/rv32_load_ext.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module rv32_load_ext
  import rv32_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[{offset_i, 3'b000} +: 8];
    half_v = word_i[{offset_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data_o = {24'h0, byte_v};
      F3_H:    data_o = {{16{half_v[15]}}, half_v};
      F3_HU:   data_o = {16'h0, half_v};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/rv32_lsu.sv
// RV32I load/store unit: validates and aligns a request, runs one req/gnt/rvalid bus
// transaction with a timeout, and returns extended load data with a done/err pulse.
module rv32_lsu
  import rv32_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic        req_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_cause_o,
  output logic [31:0] rdata_o,
  rv32_lsu_if.master  mem
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  lsu_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            store_q, store_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      cause_q, cause_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;

  logic [31:0]     store_data;
  logic [31:0]     load_data;
  logic            timed_out;

  rv32_load_ext u_load_ext (
    .word_i   (mem.rdata),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .data_o   (load_data)
  );

  always_comb begin
    case (req_funct3_i[1:0])
      2'b00:   store_data = {24'h0, req_wdata_i[7:0]} << {req_addr_i[1:0], 3'b000};
      2'b01:   store_data = {16'h0, req_wdata_i[15:0]} << {req_addr_i[1], 4'b0000};
      default: store_data = req_wdata_i;
    endcase
  end

  // Counter was cleared on entry to REQ, so this fires after TIMEOUT cycles in REQ+WAIT.
  assign timed_out = cnt_q >= CntW'(TIMEOUT - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    off_d   = off_q;
    store_d = store_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cause_d = cause_q;
    rdata_d = rdata_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (!f3_legal(req_store_i, req_funct3_i)) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            cause_d = ERR_ILLEGAL;
          end else if (f3_misaligned(req_funct3_i, req_addr_i[1:0])) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            cause_d = ERR_MISALIGN;
          end else begin
            f3_d    = req_funct3_i;
            off_d   = req_addr_i[1:0];
            store_d = req_store_i;
            addr_d  = {req_addr_i[31:2], 2'b00};
            be_d    = lsu_be(req_funct3_i, req_addr_i[1:0]);
            wdata_d = req_store_i ? store_data : 32'h0;
            we_d    = req_store_i;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem.gnt) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (store_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end else if (timed_out) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          cause_d = ERR_TIMEOUT;
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem.rvalid) begin
          rdata_d = load_data;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timed_out) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          cause_d = ERR_TIMEOUT;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      store_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cause_q <= '0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      store_q <= store_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cause_q <= cause_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy_o      = state_q != IDLE;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_cause_o = cause_q;
  assign rdata_o     = rdata_q;
  assign mem.req     = req_q;
  assign mem.we      = we_q;
  assign mem.addr    = addr_q;
  assign mem.be      = be_q;
  assign mem.wdata   = wdata_q;

endmodule

// File: tb/tb_rv32_lsu.sv
// Scenario bench for rv32_lsu: expected completions are queued at issue time and popped
// when done pulses; bus-side signals are checked inline per scenario.
module tb_rv32_lsu;
  import rv32_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        busy, done, err;
  logic [1:0]  err_cause;
  logic [31:0] rdata;

  rv32_lsu_if mem_if ();

  rv32_lsu #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_store_i  (req_store),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .err_cause_o  (err_cause),
    .rdata_o      (rdata),
    .mem          (mem_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [1:0]  cause;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] word;
    logic [31:0] res;
    logic [3:0]  be;
  } ld_vec_t;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [1:0]  cause;
  } er_vec_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_rdata = 32'h0;
  logic [1:0]  m_cause = 2'b00;

  function automatic void push_load(input logic [31:0] d);
    m_rdata = d;
    exp_q.push_back('{err: 1'b0, cause: m_cause, rdata: d});
  endfunction

  function automatic void push_store();
    exp_q.push_back('{err: 1'b0, cause: m_cause, rdata: m_rdata});
  endfunction

  function automatic void push_err(input logic [1:0] c);
    m_cause = c;
    exp_q.push_back('{err: 1'b1, cause: c, rdata: m_rdata});
  endfunction

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = done;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      seen = done;
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({busy, done, err, err_cause, rdata, mem_if.req, mem_if.we, mem_if.addr, mem_if.be,
         mem_if.wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset: got busy=%b done=%b err=%b cause=%b rdata=%h req=%b we=%b addr=%h be=%b wdata=%h want all zero",
               busy, done, err, err_cause, rdata, mem_if.req, mem_if.we, mem_if.addr,
               mem_if.be, mem_if.wdata);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_word();
    exp_t e;
    bit   seen;
    mem_if.gnt = 1'b1;
    push_load(32'hDEADBEEF);
    issue(1'b0, F3_W, 32'h100, 32'h0);
    n_cmp++;
    if ({mem_if.req, mem_if.we, mem_if.addr, mem_if.be, busy} !== {1'b1, 1'b0, 32'h100, 4'hF, 1'b1})
    begin
      n_bad++;
      $display("FAIL lw.bus: got req=%b we=%b addr=%h be=%b busy=%b want 1 0 00000100 1111 1",
               mem_if.req, mem_if.we, mem_if.addr, mem_if.be, busy);
    end
    @(negedge clk);
    mem_if.gnt = 1'b0;
    n_cmp++;
    if ({mem_if.req, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL lw.req_drop: got req=%b busy=%b want 0 1", mem_if.req, busy);
    end
    @(negedge clk);
    mem_if.rvalid = 1'b1;
    mem_if.rdata  = 32'hDEADBEEF;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL lw.early_done: got done=%b want 0", done);
    end
    @(negedge clk);
    mem_if.rvalid = 1'b0;
    seen = done;
    n_cmp++;
    if (!seen || exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL lw.done: got done=%b queued=%0d want done=1 one cycle after rvalid",
               done, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({err, rdata} !== {e.err, e.rdata}) begin
        n_bad++;
        $display("FAIL lw.result: got err=%b rdata=%h want err=%b rdata=%h",
                 err, rdata, e.err, e.rdata);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({done, rdata} !== {1'b0, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL lw.hold: got done=%b rdata=%h want 0 deadbeef", done, rdata);
    end
  endtask

  task automatic test_load_extend();
    ld_vec_t tab [8];
    exp_t    e;
    bit      seen;
    tab = '{'{F3_B,  32'h103, 32'h80123456, 32'hFFFFFF80, 4'b1000},
            '{F3_BU, 32'h103, 32'h80123456, 32'h00000080, 4'b1000},
            '{F3_HU, 32'h102, 32'h80123456, 32'h00008012, 4'b1100},
            '{F3_H,  32'h102, 32'h80123456, 32'hFFFF8012, 4'b1100},
            '{F3_H,  32'h100, 32'h80123456, 32'h00003456, 4'b0011},
            '{F3_B,  32'h101, 32'h80123456, 32'h00000034, 4'b0010},
            '{F3_BU, 32'h100, 32'h80123456, 32'h00000056, 4'b0001},
            '{F3_B,  32'h102, 32'h00F00000, 32'hFFFFFFF0, 4'b0100}};
    foreach (tab[i]) begin
      mem_if.gnt = 1'b1;
      push_load(tab[i].res);
      issue(1'b0, tab[i].f3, tab[i].addr, 32'h0);
      n_cmp++;
      if ({mem_if.addr, mem_if.be} !== {tab[i].addr & 32'hFFFF_FFFC, tab[i].be}) begin
        n_bad++;
        $display("FAIL ld%0d.bus: got addr=%h be=%b want addr=%h be=%b", i, mem_if.addr,
                 mem_if.be, tab[i].addr & 32'hFFFF_FFFC, tab[i].be);
      end
      @(negedge clk);
      mem_if.gnt    = 1'b0;
      mem_if.rvalid = 1'b1;
      mem_if.rdata  = tab[i].word;
      @(negedge clk);
      mem_if.rvalid = 1'b0;
      wait_done(4, seen);
      n_cmp++;
      if (!seen || exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL ld%0d.done: got done=%b queued=%0d want done=1", i, done, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if ({err, rdata} !== {e.err, e.rdata}) begin
          n_bad++;
          $display("FAIL ld%0d.result: got err=%b rdata=%h want err=%b rdata=%h", i, err, rdata,
                   e.err, e.rdata);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store_half();
    exp_t e;
    int   req_cycles = 0;
    mem_if.gnt = 1'b0;
    push_store();
    issue(1'b1, F3_H, 32'h202, 32'h1234ABCD);
    n_cmp++;
    if ({mem_if.addr, mem_if.be, mem_if.wdata[31:16], mem_if.we} !==
        {32'h200, 4'b1100, 16'hABCD, 1'b1}) begin
      n_bad++;
      $display("FAIL sh.bus: got addr=%h be=%b wdata=%h we=%b want 00000200 1100 abcdxxxx 1",
               mem_if.addr, mem_if.be, mem_if.wdata, mem_if.we);
    end
    for (int k = 1; k <= 4; k++) begin
      if (mem_if.req === 1'b1) req_cycles++;
      if (k == 4) mem_if.gnt = 1'b1;
      @(negedge clk);
    end
    mem_if.gnt = 1'b0;
    n_cmp++;
    if ({req_cycles, mem_if.req, busy} !== {32'd4, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL sh.req_len: got req_cycles=%0d req=%b busy=%b want 4 0 0", req_cycles,
               mem_if.req, busy);
    end
    n_cmp++;
    if (done !== 1'b1 || exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL sh.done: got done=%b queued=%0d want done=1 cycle after gnt", done,
               exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({err, err_cause} !== {e.err, e.cause}) begin
        n_bad++;
        $display("FAIL sh.result: got err=%b cause=%b want err=%b cause=%b", err, err_cause,
                 e.err, e.cause);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_store_byte();
    exp_t e;
    bit   seen;
    mem_if.gnt = 1'b1;
    push_store();
    issue(1'b1, F3_B, 32'h301, 32'hCAFE12EF);
    n_cmp++;
    if ({mem_if.addr, mem_if.be, mem_if.wdata[15:8], mem_if.we, mem_if.req} !==
        {32'h300, 4'b0010, 8'hEF, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL sb.bus: got addr=%h be=%b wdata=%h we=%b req=%b want 00000300 0010 xxxxefxx 1 1",
               mem_if.addr, mem_if.be, mem_if.wdata, mem_if.we, mem_if.req);
    end
    @(negedge clk);
    mem_if.gnt = 1'b0;
    wait_done(0, seen);
    n_cmp++;
    if (!seen || exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL sb.done: got done=%b queued=%0d want done=1", done, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (err !== e.err) begin
        n_bad++;
        $display("FAIL sb.result: got err=%b want err=%b", err, e.err);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_errors();
    er_vec_t tab [8];
    exp_t    e;
    tab = '{'{1'b0, F3_W,   32'h102, ERR_MISALIGN},
            '{1'b1, 3'b011, 32'h100, ERR_ILLEGAL},
            '{1'b0, F3_H,   32'h101, ERR_MISALIGN},
            '{1'b1, 3'b011, 32'h103, ERR_ILLEGAL},
            '{1'b0, 3'b110, 32'h100, ERR_ILLEGAL},
            '{1'b1, F3_BU,  32'h100, ERR_ILLEGAL},
            '{1'b1, F3_H,   32'h103, ERR_MISALIGN},
            '{1'b0, F3_HU,  32'h201, ERR_MISALIGN}};
    foreach (tab[i]) begin
      push_err(tab[i].cause);
      issue(tab[i].st, tab[i].f3, tab[i].addr, 32'h55AA55AA);
      n_cmp++;
      if ({mem_if.req, busy, done} !== 3'b001 || exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL err%0d.done: got req=%b busy=%b done=%b want 0 0 1", i, mem_if.req,
                 busy, done);
      end else begin
        e = exp_q.pop_front();
        if ({err, err_cause, rdata} !== {e.err, e.cause, e.rdata}) begin
          n_bad++;
          $display("FAIL err%0d.result: got err=%b cause=%b rdata=%h want err=%b cause=%b rdata=%h",
                   i, err, err_cause, rdata, e.err, e.cause, e.rdata);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int   req_cycles = 0;
    mem_if.gnt = 1'b0;
    push_err(ERR_TIMEOUT);
    issue(1'b0, F3_W, 32'h400, 32'h0);
    for (int c = 0; c < 40 && done !== 1'b1; c++) begin
      if (mem_if.req === 1'b1) req_cycles++;
      @(negedge clk);
    end
    n_cmp++;
    if (req_cycles != TO) begin
      n_bad++;
      $display("FAIL timeout.len: got req_cycles=%0d want %0d", req_cycles, TO);
    end
    n_cmp++;
    if ({done, mem_if.req, busy} !== 3'b100 || exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL timeout.done: got done=%b req=%b busy=%b want 1 0 0", done, mem_if.req,
               busy);
    end else begin
      e = exp_q.pop_front();
      if ({err, err_cause, rdata} !== {e.err, e.cause, e.rdata}) begin
        n_bad++;
        $display("FAIL timeout.result: got err=%b cause=%b rdata=%h want err=%b cause=%b rdata=%h",
                 err, err_cause, rdata, e.err, e.cause, e.rdata);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   seen;
    push_err(ERR_MISALIGN);
    issue(1'b0, F3_W, 32'h101, 32'h0);
    n_cmp++;
    if (done !== 1'b1 || exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL b2b.first: got done=%b want 1", done);
    end else begin
      e = exp_q.pop_front();
      if ({err, err_cause} !== {e.err, e.cause}) begin
        n_bad++;
        $display("FAIL b2b.first_result: got err=%b cause=%b want err=%b cause=%b", err,
                 err_cause, e.err, e.cause);
      end
    end
    mem_if.gnt = 1'b1;
    push_load(32'h00000034);
    issue(1'b0, F3_BU, 32'h101, 32'h0);
    n_cmp++;
    if ({mem_if.req, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL b2b.accept: got req=%b busy=%b want 1 1", mem_if.req, busy);
    end
    @(negedge clk);
    mem_if.gnt    = 1'b0;
    mem_if.rvalid = 1'b1;
    mem_if.rdata  = 32'h80123456;
    @(negedge clk);
    mem_if.rvalid = 1'b0;
    wait_done(4, seen);
    n_cmp++;
    if (!seen || exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL b2b.done: got done=%b want 1", done);
    end else begin
      e = exp_q.pop_front();
      if ({err, rdata} !== {e.err, e.rdata}) begin
        n_bad++;
        $display("FAIL b2b.result: got err=%b rdata=%h want err=%b rdata=%h", err, rdata,
                 e.err, e.rdata);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   seen;
    bit   stray = 1'b0;
    mem_if.gnt = 1'b1;
    push_load(32'h0BADF00D);
    issue(1'b0, F3_W, 32'h100, 32'h0);
    @(negedge clk);
    mem_if.gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_rdata = 32'h0;
    m_cause = 2'b00;
    n_cmp++;
    if ({busy, done, err, err_cause, rdata, mem_if.req, mem_if.we, mem_if.addr, mem_if.be,
         mem_if.wdata} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid.outs: got busy=%b done=%b err=%b rdata=%h req=%b addr=%h be=%b want all zero",
               busy, done, err, rdata, mem_if.req, mem_if.addr, mem_if.be);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_if.rvalid = 1'b1;
    mem_if.rdata  = 32'h0BADF00D;
    @(negedge clk);
    mem_if.rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if ({stray, rdata} !== {1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL rst_mid.stray_rvalid: got stray_done_or_busy=%b rdata=%h want 0 00000000",
               stray, rdata);
    end
    mem_if.gnt = 1'b1;
    push_store();
    issue(1'b1, F3_W, 32'h300, 32'h89ABCDEF);
    n_cmp++;
    if ({mem_if.req, mem_if.we, mem_if.addr, mem_if.be, mem_if.wdata} !==
        {1'b1, 1'b1, 32'h300, 4'hF, 32'h89ABCDEF}) begin
      n_bad++;
      $display("FAIL sw.bus: got req=%b we=%b addr=%h be=%b wdata=%h want 1 1 00000300 1111 89abcdef",
               mem_if.req, mem_if.we, mem_if.addr, mem_if.be, mem_if.wdata);
    end
    @(negedge clk);
    mem_if.gnt = 1'b0;
    wait_done(0, seen);
    n_cmp++;
    if (!seen || exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL sw.done: got done=%b want 1", done);
    end else begin
      e = exp_q.pop_front();
      if ({err, err_cause} !== {e.err, e.cause}) begin
        n_bad++;
        $display("FAIL sw.result: got err=%b cause=%b want err=%b cause=%b", err, err_cause,
                 e.err, e.cause);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard.drain: got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    mem_if.gnt    = 1'b0;
    mem_if.rvalid = 1'b0;
    mem_if.rdata  = 32'h0;
    test_reset();
    test_load_word();
    test_load_extend();
    test_store_half();
    test_store_byte();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rv32_lsu.md
Name: rv32_lsu

Overview:
Load/store unit directly downstream of the ALU in the RV32I core. It takes the ALU result `y` as the effective address, aligns store data and byte enables, and drives a req/gnt/rvalid data-memory bus. It returns sign- or zero-extended load data to writeback. The core stalls on `busy`; the unit also reports misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT, 16, cycles allowed in REQ+WAIT before a bus-timeout error (must be >= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
req_valid  input  1  start access (sampled only in IDLE)
req_store  input  1  1=store, 0=load
req_funct3  input  3  RV32I width/sign field
req_addr  input  32  effective address (ALU y)
req_wdata  input  32  store data (rs2)
busy  output  1  state != IDLE (combinational from state)
done  output  1  one-cycle completion pulse
err  output  1  one-cycle error pulse, coincident with done
err_cause  output  2  00 misaligned, 01 timeout, 10 illegal funct3; valid when err=1
rdata  output  32  extended load data, held until next done
mem_req  output  1  bus request
mem_we  output  1  write enable
mem_addr  output  32  word address (req_addr with [1:0]=00)
mem_be  output  4  byte enables
mem_wdata  output  32  lane-aligned store data
mem_gnt  input  1  request accepted
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read data word

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; timeout counter=0; done, err, mem_req, mem_we=0; err_cause=00; rdata, mem_addr, mem_be, mem_wdata=0.
- funct3 encoding:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Misalignment: halfword with addr[0]=1; word with addr[1:0]!=00.
- IDLE, req_valid=1, illegal funct3 → next cycle: done=1, err=1, err_cause=10; no mem_req.
- IDLE, req_valid=1, legal but misaligned → next cycle: done=1, err=1, err_cause=00; no mem_req. Illegal takes priority over misaligned.
- IDLE, req_valid=1, legal and aligned:
  - Latch funct3, addr[1:0], req_store.
  - Register mem_addr, mem_be, mem_wdata, mem_we.
  - Assert mem_req; go to REQ.
- Store alignment:
  - SB: be=0001<<a, wdata=req_wdata[7:0] at bits 8a+7:8a.
  - SH: be=0011<<a, wdata=req_wdata[15:0] at bits 16·a[1]+15:16·a[1].
  - SW: be=1111, wdata=req_wdata.
  - Loads: be computed the same way; mem_wdata=0.
- REQ: mem_req held high until mem_gnt is sampled high.
  - On gnt: mem_req=0.
  - Store: → IDLE with done=1 next cycle.
  - Load: → WAIT.
- WAIT: on mem_rvalid → IDLE. rdata and done=1 are registered at that edge, so done rises the cycle after rvalid.
- Load extraction:
  - LB/LBU: byte a.
  - LH/LHU: halfword a[1].
  - LW: full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - If it reaches TIMEOUT-1 without completion: → IDLE, mem_req=0, done=1, err=1, err_cause=01 next cycle.
  - On a timed-out load, rdata is unchanged.
- Stores complete on gnt; mem_rvalid is ignored except in WAIT. Stray rvalid in IDLE or REQ has no effect.
- req_valid is ignored while busy; the core must hold its request stable until done.
- Back-to-back: a new request is accepted in the same cycle done is high (state is already IDLE).
- Reset mid-operation: immediate return to IDLE, outputs to reset values. An rvalid arriving after reset is ignored.
- Successful completion: err=0; err_cause is not updated.

Decomposition:
- Shared package rv32_pkg:
  - funct3 load/store localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - lsu_state_t enum {IDLE, REQ, WAIT}.
  - err_cause localparams.
- One combinational sub-module rv32_load_ext handles byte/halfword extraction and sign/zero extension. Inputs: word, offset, funct3.
- Store alignment stays inline in rv32_lsu.

Test Plan:
- LW addr 0x100; gnt in the req cycle; rvalid 2 cycles later with 0xDEADBEEF → mem_addr=0x100, be=1111, we=0; done one cycle after rvalid; rdata=0xDEADBEEF; err=0.
- LB addr 0x103, mem_rdata=0x80123456 → rdata=0xFFFFFF80. Repeat with LBU → 0x00000080. LHU addr 0x102 → 0x00008012.
- SH addr 0x202, wdata 0x1234ABCD; gnt delayed 3 cycles → mem_req held 4 cycles; mem_addr=0x200, be=1100, wdata[31:16]=0xABCD, we=1; done cycle after gnt.
- LW addr 0x102 → no mem_req; next cycle done=1, err=1, err_cause=00. Store with funct3=011 → err_cause=10.
- Load, gnt=0 forever, TIMEOUT=16 → done=err=1, cause=01 after 16 cycles; mem_req then low; busy low.
- Reset asserted in WAIT, then rvalid pulsed → all outputs zero, state IDLE, no done. A new SW at 0x300 afterwards completes normally.
